// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU operation codes, control-FSM states and
// the control-word layout used by the control unit, datapath and ALU.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU codes share the opcode numbering of the matching instructions
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_ROR  = 5'b00111;
  localparam logic [4:0] ALU_ROL  = 5'b01000;
  localparam logic [4:0] ALU_SHR  = 5'b01001;
  localparam logic [4:0] ALU_SHRA = 5'b01010;
  localparam logic [4:0] ALU_SHL  = 5'b01011;
  localparam logic [4:0] ALU_DIV  = 5'b01111;
  localparam logic [4:0] ALU_MUL  = 5'b10000;
  localparam logic [4:0] ALU_NEG  = 5'b10001;
  localparam logic [4:0] ALU_NOT  = 5'b10010;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_WAIT, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out;
    logic       mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, outport_in, con_in, r_in;
    logic       gra, grb, grc, r_out, ba_out, inc_pc, read, write;
    logic [4:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit bus: instruction/flag inputs from the datapath and the
// per-cycle control strobes back to it.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON_FF, Stop, Run;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, Rin;
  logic        Gra, Grb, Grc, Rout, BAout, IncPC, Read, Write;
  logic [4:0]  ALUop;

  modport master (
    input  IR, CON_FF, Stop,
    output Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
           MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, Rin,
           Gra, Grb, Grc, Rout, BAout, IncPC, Read, Write, ALUop
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
           MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, Rin,
           Gra, Grb, Grc, Rout, BAout, IncPC, Read, Write, ALUop
  );
endinterface

// File: rtl/control_unit_mem_wait_ctr.sv
// Down-counter that stretches a memory state to 1+MEM_WAIT cycles; it reloads
// whenever the FSM is outside a memory state.
module mem_wait_ctr #(
  parameter int MEM_WAIT = 1
) (
  input  logic Clock,
  input  logic Clear,
  input  logic in_mem,
  output logic done
);
  localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT);

  logic [1:0] count_reg;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear)                  count_reg <= WAIT_INIT;
    else if (!in_mem)            count_reg <= WAIT_INIT;
    else if (count_reg != 2'd0)  count_reg <= count_reg - 2'd1;
  end

  assign done = in_mem && (count_reg == 2'd0);
endmodule

// File: rtl/control_unit.sv
// Moore control FSM for the CPU: fetch/decode/execute sequencing of the datapath.
// Define MUL_DIV_EN to enable the mul/div sequences (otherwise they decode as nop).
module control_unit
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master bus
);

  state_t     state_reg, state_next;
  ctrl_t      ctrl;
  logic [4:0] op;
  logic [2:0] last_step;
  logic       is_rr, is_imm, is_mem_op, is_muldiv, in_mem, mem_done, unused_ir;

  assign op        = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];
  assign is_rr     = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
  assign is_imm    = op inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign is_mem_op = op inside {OP_LD, OP_LDI, OP_ST};
`ifdef MUL_DIV_EN
  assign is_muldiv = op inside {OP_MUL, OP_DIV};
`else
  assign is_muldiv = 1'b0;
`endif

  // Index of the final T-state per opcode; 2 means fetch-only (nop/undefined)
  always_comb begin
    last_step = 3'd2;
    if (is_rr || is_imm || op == OP_LDI)                       last_step = 3'd5;
    else if (op == OP_LD || op == OP_ST)                       last_step = 3'd7;
    else if (op == OP_BR || is_muldiv)                         last_step = 3'd6;
    else if (op == OP_JAL)                                     last_step = 3'd4;
    else if (op inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO}) last_step = 3'd3;
  end

  assign in_mem = (state_reg == S_T1) ||
                  (state_reg == S_T6 && op == OP_LD) ||
                  (state_reg == S_T7 && op == OP_ST);

  mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_mem_wait (
    .Clock  (Clock),
    .Clear  (Clear),
    .in_mem (in_mem),
    .done   (mem_done)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_reg <= S_RESET;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = bus.Stop ? S_WAIT : S_T1;
      S_WAIT:  state_next = bus.Stop ? S_WAIT : S_T0;
      S_T1:    if (mem_done) state_next = S_T2;
      S_T2: begin
        if (op == OP_HALT)          state_next = S_HALT;
        else if (last_step == 3'd2) state_next = S_T0;
        else                        state_next = S_T3;
      end
      S_T3: state_next = (last_step == 3'd3) ? S_T0 : S_T4;
      S_T4: state_next = (last_step == 3'd4) ? S_T0 : S_T5;
      S_T5: state_next = (last_step == 3'd5) ? S_T0 : S_T6;
      S_T6: if (!in_mem || mem_done) state_next = (last_step == 3'd6) ? S_T0 : S_T7;
      S_T7: if (!in_mem || mem_done) state_next = S_T0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (state_reg)
      S_T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1; end
      S_T1: begin ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
      S_T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
      S_T3: begin
        if (is_rr || is_imm) begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
        else if (is_mem_op)  begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
        else if (is_muldiv)  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
        else begin
          case (op)
            OP_BR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
            OP_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
            OP_JAL:  begin ctrl.pc_out = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1; end
            OP_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            OP_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
            OP_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            OP_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_rr || is_muldiv) begin
          ctrl.grc    = is_rr;
          ctrl.grb    = is_muldiv;
          ctrl.r_out  = 1'b1;
          ctrl.z_in   = 1'b1;
          ctrl.alu_op = op;
        end else if (is_imm) begin
          ctrl.c_out  = 1'b1;
          ctrl.z_in   = 1'b1;
          ctrl.alu_op = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_ADD;
        end else if (is_mem_op) begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
        else if (op == OP_BR)  begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
        else if (op == OP_JAL) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
      end
      S_T5: begin
        if (is_rr || is_imm || op == OP_LDI) begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
        else if (is_mem_op) begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
        else if (op == OP_BR) begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
        else if (is_muldiv) begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
      end
      S_T6: begin
        if (op == OP_LD)      begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
        else if (op == OP_ST) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
        else if (op == OP_BR) begin ctrl.zlow_out = bus.CON_FF; ctrl.pc_in = bus.CON_FF; end
        else if (is_muldiv)   begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
      end
      S_T7: begin
        if (op == OP_LD)      begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
        else if (op == OP_ST) ctrl.write = 1'b1;
      end
      default: ;
    endcase
`ifndef MUL_DIV_EN
    ctrl.hi_in = 1'b0;
    ctrl.lo_in = 1'b0;
`endif
  end

  assign bus.Run       = (state_reg != S_HALT) && (state_reg != S_RESET);
  assign bus.PCout     = ctrl.pc_out;
  assign bus.Zhighout  = ctrl.zhigh_out;
  assign bus.Zlowout   = ctrl.zlow_out;
  assign bus.MDRout    = ctrl.mdr_out;
  assign bus.HIout     = ctrl.hi_out;
  assign bus.LOout     = ctrl.lo_out;
  assign bus.InPortout = ctrl.inport_out;
  assign bus.Cout      = ctrl.c_out;
  assign bus.MARin     = ctrl.mar_in;
  assign bus.Zin       = ctrl.z_in;
  assign bus.PCin      = ctrl.pc_in;
  assign bus.MDRin     = ctrl.mdr_in;
  assign bus.IRin      = ctrl.ir_in;
  assign bus.Yin       = ctrl.y_in;
  assign bus.HIin      = ctrl.hi_in;
  assign bus.LOin      = ctrl.lo_in;
  assign bus.OutPortin = ctrl.outport_in;
  assign bus.CONin     = ctrl.con_in;
  assign bus.Rin       = ctrl.r_in;
  assign bus.Gra       = ctrl.gra;
  assign bus.Grb       = ctrl.grb;
  assign bus.Grc       = ctrl.grc;
  assign bus.Rout      = ctrl.r_out;
  assign bus.BAout     = ctrl.ba_out;
  assign bus.IncPC     = ctrl.inc_pc;
  assign bus.Read      = ctrl.read;
  assign bus.Write     = ctrl.write;
  assign bus.ALUop     = ctrl.alu_op;

endmodule
